data_ram: RTL and testbench
===========================

Name: data_ram

Overview:
- Responder side of the core's data-memory handshake: synchronous single-port byte-writable RAM.
- Sits between the control unit/dataflow (data_mem_enable, data_mem_byte_write_enable, address, write data) and the core's data bus.
- Answers each request with a fixed-length busy pulse, the same protocol the instruction ROM uses: the initiator raises enable, sees busy rise, then waits for busy to fall.
- Replaces the hand-driven data_mem_busy stimulus in core benches.

Parameters:
- RAM_INIT_FILE, "", binary MIF loaded with $readmemb at elaboration; empty string means no load, contents start X.
- ADDR_SIZE, 10, byte-address width; memory depth is 2^ADDR_SIZE bytes.
- OFFSET, 3, log2 of bytes per word; fixed at 3 for the 64-bit bus.
- BUSY_CYCLES, 4, number of cycles busy stays high per access; legal range is 1 or more.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- enable  input  1  access request from control unit.
- byte_write_enable  input  8  per-byte write strobe; 0 means read.
- addr  input  ADDR_SIZE  byte address; the low OFFSET bits are ignored (word-aligned access).
- write_data  input  64  store data; byte k is write_data[8k+7:8k].
- read_data  output  64  load data, registered.
- busy  output  1  access in progress, registered.

Behaviour:
- Reset values: busy=0, read_data=0, state IDLE, cycle counter 0. Memory array is not cleared.
- Storage is little-endian. Word w consists of bytes 8w .. 8w+7, with byte 0 in bits [7:0].
- State IDLE:
  - Stays in IDLE while enable=0.
  - On the edge where enable=1: latch addr[ADDR_SIZE-1:OFFSET], byte_write_enable and write_data; set busy=1; load counter=BUSY_CYCLES-1; go to BUSY.
- State BUSY:
  - While counter is not 0: decrement the counter each edge.
  - On the edge where counter=0, the access is performed:
    - Latched strobe = 0 (read): read_data is loaded with the addressed word.
    - Latched strobe not 0 (write): each byte with a set strobe bit is written from the latched data; bytes with a clear strobe keep their value; read_data is unchanged.
  - On that same edge busy goes to 0 and the FSM moves to DONE.
- Timing: busy is high for exactly BUSY_CYCLES cycles. read_data is valid in the first cycle busy=0 and holds until the next completed read or a reset.
- State DONE: go to IDLE when enable=0; otherwise stay. A held enable never starts a second access; the initiator must drop enable for at least one cycle between requests.
- Inputs are ignored outside the IDLE accept edge. Changes to addr, write_data or strobes during BUSY, and enable dropping during BUSY, do not affect the access in flight, which always completes.
- Reset during BUSY: the access is aborted with no write, busy=0 on the next edge, and the FSM returns to IDLE. Reset together with the final BUSY edge: reset wins and no write occurs.
- Addresses wrap modulo 2^ADDR_SIZE through truncation. There is no out-of-range condition.
- BUSY_CYCLES=1: busy is high for one cycle, and the access is performed on the edge after the accept edge.

Optional Feature:
- Macro: DATA_RAM_ACCESS_COUNT_EN.
- Defined:
  - Adds output ports read_count (32 bits) and write_count (32 bits).
  - Both reset to 0.
  - Each increments by 1 on the edge where a read or write, respectively, completes.
  - Both saturate at 32'hFFFFFFFF.
  - Aborted accesses are not counted.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset with BUSY_CYCLES=4 -> busy=0, read_data=64'h0, enable ignored during reset; memory keeps the init-file contents.
2. Write addr=10'h010, strobe=8'hFF, data=64'h0123456789ABCDEF, enable held high -> busy high exactly 4 cycles, no second access while enable stays 1; then read addr=10'h017 with strobe 0 -> read_data=64'h0123456789ABCDEF once busy falls.
3. Partial store: strobe=8'h0C, data=64'h0000_0000_AABB_0000 to addr 10'h010 -> a read of 10'h010 returns 64'h01234567AABBCDEF.
4. Write to addr=10'h3F8 then read from addr=10'h7F8 (the bit above ADDR_SIZE is truncated) -> same word returned; toggle addr and data during BUSY -> the latched values are used.
5. Assert reset for 1 cycle in the second BUSY cycle of a write with data=64'hFFFF_FFFF_FFFF_FFFF -> busy=0 next edge; a following read returns the old word unchanged.
6. With DATA_RAM_ACCESS_COUNT_EN defined: 3 reads, 2 writes, 1 aborted write -> read_count=3, write_count=2.

Source files
------------

// File: rtl/data_ram.sv
// data_ram: byte-writable single-port data RAM answering each request with a fixed-length busy pulse.
// Optional read/write access counters are enabled by defining DATA_RAM_ACCESS_COUNT_EN.
module data_ram #(
  parameter string RAM_INIT_FILE = "",
  parameter int    ADDR_SIZE     = 10,
  parameter int    OFFSET        = 3,
  parameter int    BUSY_CYCLES   = 4
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [7:0]           byte_write_enable_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [63:0]          write_data_i,
  output logic [63:0]          read_data_o,
  output logic                 busy_o
`ifdef DATA_RAM_ACCESS_COUNT_EN
  ,
  output logic [31:0]          read_count_o,
  output logic [31:0]          write_count_o
`endif
);
  localparam int CW = BUSY_CYCLES > 1 ? $clog2(BUSY_CYCLES) : 1;
  localparam int WA = ADDR_SIZE - OFFSET;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [WA-1:0]   waddr_q;
  logic [7:0]      be_q;
  logic [63:0]     wdata_q;
  logic [63:0]     read_data_q;
  logic            busy_q;
  logic [63:0]     rd_word;
  logic            fire;
  logic            unused_low;
  logic [7:0]      mem [2**ADDR_SIZE];
  assign unused_low  = ^addr_i[OFFSET-1:0];
  assign fire        = state_q == BUSY && cnt_q == '0;
  assign read_data_o = read_data_q;
  assign busy_o      = busy_q;
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < 8; k++) rd_word[8*k +: 8] = mem[{waddr_q, OFFSET'(k)}];
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      read_data_q <= '0;
      cnt_q       <= '0;
    end else if (state_q == IDLE) begin
      if (enable_i) begin
        state_q <= BUSY;
        busy_q  <= 1'b1;
        cnt_q   <= CW'(BUSY_CYCLES - 1);
        waddr_q <= addr_i[ADDR_SIZE-1:OFFSET];
        be_q    <= byte_write_enable_i;
        wdata_q <= write_data_i;
      end
    end else if (state_q == BUSY) begin
      if (fire) begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        if (be_q == '0) read_data_q <= rd_word;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end else if (!enable_i) begin
      state_q <= IDLE;
    end
  end
  // A reset coinciding with the final busy edge must suppress the store.
  always_ff @(posedge clock_i) begin
    if (!reset_i && fire && be_q != '0)
      for (int k = 0; k < 8; k++)
        if (be_q[k]) mem[{waddr_q, OFFSET'(k)}] <= wdata_q[8*k +: 8];
  end
`ifdef DATA_RAM_ACCESS_COUNT_EN
  logic [31:0] read_count_q, write_count_q;
  assign read_count_o  = read_count_q;
  assign write_count_o = write_count_q;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      read_count_q  <= '0;
      write_count_q <= '0;
    end else if (fire) begin
      if (be_q == '0 && read_count_q != '1) read_count_q <= read_count_q + 1'b1;
      if (be_q != '0 && write_count_q != '1) write_count_q <= write_count_q + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed bench with a byte-array reference model checked every cycle.
module tb_data_ram;
  localparam int BC = 4;
  logic        clk = 1'b0;
  logic        rst, en;
  logic [7:0]  be;
  logic [9:0]  addr;
  logic [63:0] wd, rd;
  logic        busy;
`ifdef DATA_RAM_ACCESS_COUNT_EN
  logic [31:0] rc, wc;
`endif
  always #5 clk = ~clk;

  data_ram #(.BUSY_CYCLES(BC)) dut (
    .clock_i(clk), .reset_i(rst), .enable_i(en), .byte_write_enable_i(be),
    .addr_i(addr), .write_data_i(wd), .read_data_o(rd), .busy_o(busy)
`ifdef DATA_RAM_ACCESS_COUNT_EN
    , .read_count_o(rc), .write_count_o(wc)
`endif
  );

  int          errs = 0, checks = 0;
  bit          run = 0;
  logic        exp_busy;
  logic [63:0] exp_rd;
  int unsigned exp_rc, exp_wc;
  logic [7:0]  mdl [1024];

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (run) begin
    chk("busy", {63'd0, busy}, {63'd0, exp_busy});
    chk("read_data", rd, exp_rd);
`ifdef DATA_RAM_ACCESS_COUNT_EN
    chk("read_count", {32'd0, rc}, {32'd0, exp_rc});
    chk("write_count", {32'd0, wc}, {32'd0, exp_wc});
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic complete(logic [6:0] wa, logic [7:0] b, logic [63:0] d);
    if (b == 8'h00) begin
      for (int k = 0; k < 8; k++) exp_rd[8*k +: 8] = mdl[{wa, 3'(k)}];
      exp_rc++;
    end else begin
      for (int k = 0; k < 8; k++) if (b[k]) mdl[{wa, 3'(k)}] = d[8*k +: 8];
      exp_wc++;
    end
    exp_busy = 1'b0;
  endtask

  // mode 0: enable held after completion, 1: enable dropped during busy, 2: inputs scrambled during busy
  task automatic access(logic [7:0] b, logic [10:0] a, logic [63:0] d, int mode, int abort_at);
    en = 1'b1; be = b; addr = a[9:0]; wd = d;
    cyc();
    exp_busy = 1'b1;
    for (int i = 1; i <= BC; i++) begin
      if (mode == 2) begin
        addr = 10'($urandom);
        wd   = {$urandom, $urandom};
        be   = 8'($urandom);
      end
      if (mode == 1) en = 1'b0;
      if (i == abort_at) rst = 1'b1;
      cyc();
      if (i == abort_at) begin
        rst = 1'b0; en = 1'b0;
        exp_busy = 1'b0; exp_rd = '0; exp_rc = 0; exp_wc = 0;
        cyc();
        return;
      end
      if (i == BC) complete(a[9:3], b, d);
    end
    cyc();
    cyc();
    en = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; be = '0; addr = '0; wd = '0;
    exp_busy = 1'b0; exp_rd = '0; exp_rc = 0; exp_wc = 0;
    cyc();
    run = 1;
    cyc();
    cyc();
    rst = 1'b0; en = 1'b0;
    cyc();
    chk("reset_busy_lit", {63'd0, busy}, 64'd0);
    chk("reset_rd_lit", rd, 64'd0);
    access(8'hFF, 11'h010, 64'h0123456789ABCDEF, 0, 0);
    access(8'h00, 11'h017, 64'h0, 0, 0);
    chk("full_word_lit", rd, 64'h0123456789ABCDEF);
    access(8'h0C, 11'h010, 64'h00000000AABB0000, 1, 0);
    access(8'h00, 11'h010, 64'h0, 0, 0);
    chk("partial_store_lit", rd, 64'h01234567AABBCDEF);
    access(8'hFF, 11'h3F8, 64'hDEADBEEFCAFEF00D, 2, 0);
    access(8'h00, 11'h7F8, 64'h0, 2, 0);
    chk("wrap_latch_lit", rd, 64'hDEADBEEFCAFEF00D);
    access(8'hFF, 11'h010, 64'hFFFFFFFFFFFFFFFF, 0, 2);
    chk("abort_busy_lit", {63'd0, busy}, 64'd0);
    access(8'h00, 11'h010, 64'h0, 0, 0);
    chk("abort_no_write_lit", rd, 64'h01234567AABBCDEF);
    access(8'hFF, 11'h010, 64'hFFFFFFFFFFFFFFFF, 1, BC);
    chk("final_edge_reset_rd_lit", rd, 64'd0);
    access(8'hFF, 11'h020, 64'h1122334455667788, 0, 0);
    access(8'h81, 11'h021, 64'hAA000000000000BB, 1, 0);
    access(8'h00, 11'h020, 64'h0, 0, 0);
    chk("strobe_81_lit", rd, 64'hAA223344556677BB);
    access(8'h00, 11'h010, 64'h0, 2, 0);
    chk("final_edge_no_write_lit", rd, 64'h01234567AABBCDEF);
    access(8'h00, 11'h3FF, 64'h0, 0, 0);
    chk("reread_wrap_lit", rd, 64'hDEADBEEFCAFEF00D);
`ifdef DATA_RAM_ACCESS_COUNT_EN
    chk("read_count_lit", {32'd0, rc}, 64'd3);
    chk("write_count_lit", {32'd0, wc}, 64'd2);
`endif
    run = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
